// File: rtl/alu_muldiv_seq.sv
// Multi-cycle unsigned multiply/divide sequencer that borrows the shared
// 32-bit ALU. Multiply is shift-and-add, divide is restoring
// shift-and-subtract, one iteration per clock. The ALU is driven
// combinationally from the state and working registers.
module alu_muldiv_seq #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_FAST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_div,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [WIDTH-1:0] rsp_hi,
  output logic             rsp_dz,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res,
  input  logic [3:0]       alu_flags
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // hi: acc_hi while multiplying, partial remainder while dividing
  // lo: multiplier bits shifting out / dividend bits shifting into quotient
  // opb: multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] rsp_lo_q, rsp_lo_d;
  logic [WIDTH-1:0] rsp_hi_q, rsp_hi_d;
  logic             rsp_dz_q, rsp_dz_d;

  logic             carry;
  logic             top;
  logic             take;
  logic [WIDTH-1:0] shifted;

  // Only the borrow flag matters to the divide loop.
  logic unused_flags;
  assign unused_flags = ^{alu_flags[3:2], alu_flags[0]};

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_lo    = rsp_lo_q;
  assign rsp_hi    = rsp_hi_q;
  assign rsp_dz    = rsp_dz_q;

  // Next-state, working-register update and ALU drive.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    dz_d     = dz_q;
    rsp_lo_d = rsp_lo_q;
    rsp_hi_d = rsp_hi_q;
    rsp_dz_d = rsp_dz_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_op   = 4'h0;
    carry    = 1'b0;
    top      = hi_q[WIDTH-1];
    shifted  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    take     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          hi_d  = '0;
          lo_d  = req_div ? req_a : req_b;
          opb_d = req_div ? req_b : req_a;
          cnt_d = CW'(WIDTH);
          dz_d  = req_div && (req_b == '0);
          if (!req_div) begin
            state_d = MUL;
          end else if ((req_b == '0) && ZERO_FAST) begin
            // Divide-by-zero short cut: the answer the loop would produce.
            state_d  = DONE;
            rsp_lo_d = '1;
            rsp_hi_d = req_a;
            rsp_dz_d = 1'b1;
          end else begin
            state_d = DIV;
          end
        end
      end

      MUL: begin
        alu_a  = hi_q;
        alu_b  = lo_q[0] ? opb_q : '0;
        alu_op = 4'h0;
        carry  = (alu_res < hi_q);
        hi_d   = {carry, alu_res[WIDTH-1:1]};
        lo_d   = {alu_res[0], lo_q[WIDTH-1:1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          rsp_hi_d = hi_d;
          rsp_lo_d = lo_d;
          rsp_dz_d = 1'b0;
        end
      end

      DIV: begin
        alu_a  = shifted;
        alu_b  = opb_q;
        alu_op = 4'h1;
        // A set top bit means the shifted remainder exceeds any divisor.
        take   = top | ~alu_flags[1];
        hi_d   = take ? alu_res : shifted;
        lo_d   = {lo_q[WIDTH-2:0], take};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          rsp_hi_d = hi_d;
          rsp_lo_d = lo_d;
          rsp_dz_d = dz_q;
        end
      end

      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and working registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      dz_q     <= 1'b0;
      rsp_lo_q <= '0;
      rsp_hi_q <= '0;
      rsp_dz_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      dz_q     <= dz_d;
      rsp_lo_q <= rsp_lo_d;
      rsp_hi_q <= rsp_hi_d;
      rsp_dz_q <= rsp_dz_d;
    end
  end

endmodule
